spin_supervisor: RTL and testbench

- Sequences a motor spin-up and supervises it using the event rate reported by window_counter (hall/commutation events per sliding window).
- Owns the window counter's reset and gates commutation drive.
- Declares running once the rate crosses a start threshold, retries failed starts, and latches stall/overspeed faults.
- Sits between the host command interface and the commutation datapath.

---
 rtl/bldc_supervisor_pkg.sv | 24 ++
 rtl/tick_divider.sv | 30 +++
 rtl/spin_supervisor.sv | 169 ++++++++++++++++
 tb/tb_spin_supervisor.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_supervisor_pkg.sv
// Shared types and helpers for the BLDC spin-up supervisor.
// The state and fault encodings are visible on the supervisor ports.
package bldc_supervisor_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      SPINUP = 3'd2,
      RUN    = 3'd3,
      FAULT  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FAULT_NONE          = 2'd0,
      FAULT_START_TIMEOUT = 2'd1,
      FAULT_STALL         = 2'd2,
      FAULT_OVERSPEED     = 2'd3
   } fault_t;

   function automatic int unsigned cycles_per_ms(input int unsigned clk_hz);
      return clk_hz / 1000;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler producing a one-cycle strobe every period_cycles cycles.
// clear restarts the count so the strobe can be realigned to an external window.
module tick_divider #(
   parameter int unsigned period_cycles = 250_000
) (
   input  logic sys_clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned cnt_w = (period_cycles > 1) ? $clog2(period_cycles) : 1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(period_cycles - 1);

   logic [cnt_w-1:0] cnt;

   always_ff @(posedge sys_clk) begin
      if (!reset_n || clear) begin
         cnt <= '0;
      end else if (cnt == cnt_last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Strobe is high during the last cycle of each period.
   assign tick = (cnt == cnt_last);

endmodule

// File: rtl/spin_supervisor.sv
// Motor spin-up sequencer and run supervisor driven by the window_counter rate.
// Owns the window counter reset, gates commutation drive and latches faults.
module spin_supervisor
   import bldc_supervisor_pkg::*;
#(
   parameter int unsigned clk_freq_hz      = 50_000_000,
   parameter int unsigned sample_time_ms   = 5,
   parameter int unsigned counter_width    = 12,
   parameter int unsigned start_min        = 10,
   parameter int unsigned stall_min        = 4,
   parameter int unsigned stall_confirm    = 3,
   parameter int unsigned overspeed_max    = 2000,
   parameter int unsigned start_timeout_ms = 500,
   parameter int unsigned max_retries      = 2,
   localparam int unsigned retry_w = (max_retries > 0) ? $clog2(max_retries + 1) : 1
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     fault_clear,
   input  logic [counter_width-1:0] counter,
   input  logic                     valid,
   output logic                     win_reset_n,
   output logic                     drive_enable,
   output logic                     run_ok,
   output state_t                   state,
   output logic [1:0]               fault_code,
   output logic [retry_w-1:0]       retry_count
);

   localparam int unsigned period_cycles   = sample_time_ms * cycles_per_ms(clk_freq_hz);
   localparam int unsigned timeout_strobes = start_timeout_ms / sample_time_ms;
   localparam int unsigned tmo_w   = (timeout_strobes > 1) ? $clog2(timeout_strobes) : 1;
   localparam int unsigned stall_w = (stall_confirm > 0) ? $clog2(stall_confirm + 1) : 1;

   localparam logic [counter_width-1:0] start_min_c     = counter_width'(start_min);
   localparam logic [counter_width-1:0] stall_min_c     = counter_width'(stall_min);
   localparam logic [counter_width-1:0] overspeed_max_c = counter_width'(overspeed_max);
   localparam logic [tmo_w-1:0]         tmo_last        = tmo_w'(timeout_strobes - 1);
   localparam logic [stall_w-1:0]       stall_confirm_c = stall_w'(stall_confirm);
   localparam logic [retry_w-1:0]       retry_max       = retry_w'(max_retries);

   state_t               state_next;
   fault_t               fault_q, fault_next;
   logic [retry_w-1:0]   retry_q, retry_next;
   logic [tmo_w-1:0]     tmo_cnt, tmo_next;
   logic [stall_w-1:0]   stall_cnt, stall_next, stall_inc;
   logic                 tick;
   logic                 eval_over, eval_low, spin_ok;

   tick_divider #(
      .period_cycles (period_cycles)
   ) u_tick (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .clear   (state == CLEAR),
      .tick    (tick)
   );

   // Evaluation qualifiers; a strobe without valid data counts as a stalled sample.
   assign spin_ok   = tick && valid && (counter >= start_min_c);
   assign eval_over = tick && valid && (counter > overspeed_max_c);
   assign eval_low  = tick && (!valid || (counter < stall_min_c));
   assign stall_inc = (stall_cnt >= stall_confirm_c) ? stall_cnt : stall_cnt + 1'b1;

   always_comb begin
      state_next = state;
      fault_next = fault_q;
      retry_next = retry_q;
      tmo_next   = tmo_cnt;
      stall_next = stall_cnt;

      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_next = CLEAR;
               retry_next = '0;
            end
         end

         CLEAR: begin
            tmo_next   = '0;
            stall_next = '0;
            state_next = SPINUP;
         end

         SPINUP: begin
            if (stop) begin
               state_next = IDLE;
            end else if (spin_ok) begin
               state_next = RUN;
            end else if (tick) begin
               if (tmo_cnt == tmo_last) begin
                  if (retry_q < retry_max) begin
                     retry_next = retry_q + 1'b1;
                     state_next = CLEAR;
                  end else begin
                     fault_next = FAULT_START_TIMEOUT;
                     state_next = FAULT;
                  end
               end else begin
                  tmo_next = tmo_cnt + 1'b1;
               end
            end
         end

         RUN: begin
            // A fault found on this strobe takes precedence over a coincident stop.
            if (eval_over) begin
               fault_next = FAULT_OVERSPEED;
               state_next = FAULT;
            end else if (eval_low && (stall_inc >= stall_confirm_c)) begin
               stall_next = stall_inc;
               fault_next = FAULT_STALL;
               state_next = FAULT;
            end else begin
               if (eval_low) begin
                  stall_next = stall_inc;
               end else if (tick) begin
                  stall_next = '0;
               end
               if (stop) begin
                  state_next = IDLE;
               end
            end
         end

         FAULT: begin
            if (fault_clear) begin
               fault_next = FAULT_NONE;
               retry_next = '0;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         fault_q      <= FAULT_NONE;
         retry_q      <= '0;
         tmo_cnt      <= '0;
         stall_cnt    <= '0;
         win_reset_n  <= 1'b0;
         drive_enable <= 1'b0;
         run_ok       <= 1'b0;
      end else begin
         state        <= state_next;
         fault_q      <= fault_next;
         retry_q      <= retry_next;
         tmo_cnt      <= tmo_next;
         stall_cnt    <= stall_next;
         // Outputs follow the next state so they change together with state.
         win_reset_n  <= (state_next == SPINUP) || (state_next == RUN);
         drive_enable <= (state_next == SPINUP) || (state_next == RUN);
         run_ok       <= (state_next == RUN);
      end
   end

   assign fault_code  = fault_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_spin_supervisor.sv
// Bench for spin_supervisor: directed scenarios plus randomized spin-up and run
// sequences checked against a strobe-level model of the supervisor rules.
module tb_spin_supervisor;
   import bldc_supervisor_pkg::*;

   localparam int unsigned clk_hz = 2000;   // 2 cycles per ms
   localparam int p_cycles    = 10;         // 5 ms sample period
   localparam int tmo_strobes = 100;        // 500 ms / 5 ms
   localparam int cw          = 12;
   localparam int start_min   = 10;
   localparam int stall_min   = 4;
   localparam int stall_conf  = 3;
   localparam int over_max    = 2000;
   localparam int max_retries = 2;

   logic          sys_clk = 1'b0;
   logic          reset_n, start, stop, fault_clear, valid;
   logic [cw-1:0] counter;
   logic          win_reset_n, drive_enable, run_ok;
   state_t        state;
   logic [1:0]    fault_code;
   logic [1:0]    retry_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int align_cyc = 0;
   int low_run   = 0;
   logic [4:0] exp_q[$];

   spin_supervisor #(
      .clk_freq_hz (clk_hz)
   ) dut (
      .sys_clk      (sys_clk),
      .reset_n      (reset_n),
      .start        (start),
      .stop         (stop),
      .fault_clear  (fault_clear),
      .counter      (counter),
      .valid        (valid),
      .win_reset_n  (win_reset_n),
      .drive_enable (drive_enable),
      .run_ok       (run_ok),
      .state        (state),
      .fault_code   (fault_code),
      .retry_count  (retry_count)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   task automatic junk();
      counter = cw'($urandom_range(0, 4095));
      valid   = 1'($urandom_range(0, 1));
   endtask

   // Advance to the next evaluation edge, holding random data in between,
   // then present the given sample on the strobe cycle.
   task automatic do_strobe(input logic [cw-1:0] cnt, input logic vld, input logic stp,
                            input state_t pre_state);
      int nxt;
      nxt = align_cyc + p_cycles;
      while (nxt <= cyc) nxt += p_cycles;
      while (cyc < nxt - 1) begin
         junk();
         tick();
      end
      check("hold", state, pre_state);
      counter = cnt;
      valid   = vld;
      stop    = stp;
      tick();
      stop = 1'b0;
      junk();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clear_state", state, CLEAR);
      check("clear_wrn", win_reset_n, 0);
      tick();
      check("spin_state", state, SPINUP);
      check("spin_wrn", win_reset_n, 1);
      check("spin_drv", drive_enable, 1);
      align_cyc = cyc;
      low_run   = 0;
   endtask

   task automatic clear_fault();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      check("fclr_state", state, IDLE);
      check("fclr_code", fault_code, 0);
      check("fclr_retry", retry_count, 0);
      check("fclr_drv", drive_enable, 0);
   endtask

   // Spin-up model: `fails` whole attempts fail, then strobe `succ_k` succeeds.
   task automatic spin_up(input int fails, input int succ_k, input bit zero_fail,
                          output state_t res);
      state_t        es;
      logic [1:0]    ef;
      logic [cw-1:0] c;
      logic          v;
      res = SPINUP;
      for (int a = 0; a <= max_retries; a++) begin
         for (int j = 1; j <= tmo_strobes; j++) begin
            ef = 2'd0;
            if (a == fails && j == succ_k) begin
               es = RUN;
               c  = cw'($urandom_range(start_min, 4095));
               v  = 1'b1;
            end else begin
               es = SPINUP;
               if (j == tmo_strobes) begin
                  if (a < max_retries) es = CLEAR;
                  else begin
                     es = FAULT;
                     ef = 2'd1;
                  end
               end
               if (zero_fail) begin
                  c = '0;
                  v = 1'b1;
               end else if ($urandom_range(0, 3) == 0) begin
                  c = cw'($urandom_range(0, 4095));
                  v = 1'b0;
               end else begin
                  c = cw'($urandom_range(0, start_min - 1));
                  v = 1'b1;
               end
            end
            exp_q.push_back({es, ef});
            do_strobe(c, v, 1'b0, SPINUP);
            check("spin_eval", {state, fault_code}, exp_q.pop_front());
            if (es == RUN) begin
               check("spin_runok", run_ok, 1);
               check("spin_retry", retry_count, a);
               res = RUN;
               return;
            end
            if (es == FAULT) begin
               check("tmo_retry", retry_count, max_retries);
               check("tmo_drv", drive_enable, 0);
               check("tmo_wrn", win_reset_n, 0);
               res = FAULT;
               return;
            end
            if (es == CLEAR) begin
               check("retry_wrn_lo", win_reset_n, 0);
               check("retry_cnt", retry_count, a + 1);
               tick();
               check("retry_wrn_hi", win_reset_n, 1);
               check("retry_spin", state, SPINUP);
               align_cyc = cyc;
            end
         end
      end
   endtask

   // Run model: overspeed trips at once, consecutive low samples trip a stall,
   // a fault beats a coincident stop.
   task automatic run_random(input int n, output state_t res);
      state_t        es;
      logic [1:0]    ef;
      logic [cw-1:0] c;
      logic          v, s;
      int            r;
      res = RUN;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 19);
         v = 1'b1;
         if (r == 0)      c = cw'($urandom_range(over_max + 1, 4095));
         else if (r <= 6) c = cw'($urandom_range(0, stall_min - 1));
         else if (r <= 8) begin
            c = cw'($urandom_range(0, 4095));
            v = 1'b0;
         end else         c = cw'($urandom_range(stall_min, over_max));
         s  = ($urandom_range(0, 15) == 0);
         es = RUN;
         ef = 2'd0;
         if (v && c > over_max) begin
            es = FAULT;
            ef = 2'd3;
         end else if (!v || c < stall_min) begin
            low_run++;
            if (low_run >= stall_conf) begin
               es = FAULT;
               ef = 2'd2;
            end else if (s) es = IDLE;
         end else begin
            low_run = 0;
            if (s) es = IDLE;
         end
         exp_q.push_back({es, ef});
         do_strobe(c, v, s, RUN);
         check("run_eval", {state, fault_code}, exp_q.pop_front());
         if (es != RUN) begin
            res = es;
            return;
         end
      end
   endtask

   initial begin
      state_t res;
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; fault_clear = 1'b0;
      counter = '0;   valid = 1'b0;
      tick();
      tick();
      check("rst_state", state, IDLE);
      check("rst_wrn", win_reset_n, 0);
      check("rst_drv", drive_enable, 0);
      check("rst_runok", run_ok, 0);
      check("rst_fault", fault_code, 0);
      check("rst_retry", retry_count, 0);
      reset_n = 1'b1;
      tick();

      // IDLE ignores stop, fault_clear, and start colliding with stop
      stop = 1'b1; fault_clear = 1'b1;
      tick();
      stop = 1'b0; fault_clear = 1'b0;
      check("idle_ign", state, IDLE);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("idle_startstop", state, IDLE);
      check("idle_wrn", win_reset_n, 0);

      // Normal start: succeeds on the 10th strobe
      do_start();
      for (int k = 1; k <= 10; k++) begin
         do_strobe((k == 10) ? 12'd25 : 12'd0, 1'b1, 1'b0, SPINUP);
         check("norm_state", state, (k == 10) ? RUN : SPINUP);
      end
      check("norm_runok", run_ok, 1);
      check("norm_drv", drive_enable, 1);

      // Stall: 3,3 then 25 then 3,3,3
      do_strobe(12'd3, 1'b1, 1'b0, RUN);  check("stall_1", state, RUN);
      do_strobe(12'd3, 1'b1, 1'b0, RUN);  check("stall_2", state, RUN);
      do_strobe(12'd25, 1'b1, 1'b0, RUN); check("stall_3", state, RUN);
      do_strobe(12'd3, 1'b1, 1'b0, RUN);  check("stall_4", state, RUN);
      do_strobe(12'd3, 1'b1, 1'b0, RUN);  check("stall_5", state, RUN);
      do_strobe(12'd3, 1'b1, 1'b0, RUN);  check("stall_6", state, FAULT);
      check("stall_code", fault_code, 2);
      check("stall_drv", drive_enable, 0);
      check("stall_runok", run_ok, 0);
      clear_fault();

      // Overspeed colliding with stop; FAULT ignores start/stop
      do_start();
      do_strobe(12'd25, 1'b1, 1'b0, SPINUP);
      check("ovs_run", state, RUN);
      do_strobe(12'd2001, 1'b1, 1'b1, RUN);
      check("ovs_state", state, FAULT);
      check("ovs_code", fault_code, 3);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("fault_hold", state, FAULT);
      check("fault_hold_code", fault_code, 3);
      clear_fault();

      // Boundary: 2000 is not overspeed, 4 is not stalled, 10 starts
      do_start();
      do_strobe(12'd9, 1'b1, 1'b0, SPINUP);
      check("bnd_9", state, SPINUP);
      do_strobe(12'd10, 1'b1, 1'b0, SPINUP);
      check("bnd_10", state, RUN);
      do_strobe(12'd2000, 1'b1, 1'b0, RUN);
      check("bnd_2000", state, RUN);
      for (int k = 0; k < 4; k++) begin
         do_strobe(12'd4, 1'b1, 1'b0, RUN);
         check("bnd_4", state, RUN);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("run_stop", state, IDLE);
      check("run_stop_drv", drive_enable, 0);

      // Start timeout with counter held at 0
      do_start();
      spin_up(3, 0, 1'b1, res);
      check("tmo_state", state, FAULT);
      check("tmo_code", fault_code, 1);
      clear_fault();

      // Stop during SPINUP
      do_start();
      tick(); tick(); tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("spin_stop", state, IDLE);
      check("spin_stop_drv", drive_enable, 0);
      check("spin_stop_wrn", win_reset_n, 0);

      // Randomized spin-up and run sequences
      for (int t = 0; t < 5; t++) begin
         do_start();
         spin_up(($urandom_range(0, 4) == 0) ? 3 : int'($urandom_range(0, 2)),
                 int'($urandom_range(1, tmo_strobes - 1)), 1'b0, res);
         if (res == RUN) run_random(40, res);
         if (res == RUN) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("rnd_stop", state, IDLE);
         end else if (res == FAULT) begin
            check("rnd_fault_drv", drive_enable, 0);
            clear_fault();
         end else begin
            check("rnd_idle_drv", drive_enable, 0);
            check("rnd_idle_runok", run_ok, 0);
         end
      end

      // Reset mid-RUN
      do_start();
      do_strobe(12'd25, 1'b1, 1'b0, SPINUP);
      check("mid_run", state, RUN);
      reset_n = 1'b0;
      tick();
      check("mrst_state", state, IDLE);
      check("mrst_drv", drive_enable, 0);
      check("mrst_wrn", win_reset_n, 0);
      check("mrst_fault", fault_code, 0);
      check("mrst_retry", retry_count, 0);
      tick();
      reset_n = 1'b1;
      tick();
      check("mrst_after", state, IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
